// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each transaction runs IDLE -> ACCESS -> ACK; the memory is written on the edge leaving ACCESS.
module dm_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              gnt_id
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic              last_q,   last_d;
  logic              we_q,     we_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] din_q,    din_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              gnt_sel;

  // Contention goes to whoever did not win last; a lone request always wins.
  always_comb begin
    if (m0_req && m1_req) gnt_sel = ~last_q;
    else                  gnt_sel = m1_req;
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ACCESS;
          last_d  = gnt_sel;
          we_d    = gnt_sel ? m1_we    : m0_we;
          addr_d  = gnt_sel ? m1_addr  : m0_addr;
          din_d   = gnt_sel ? m1_wdata : m0_wdata;
        end
      end
      ACCESS: begin
        state_d = ACK;
        if (!we_q) begin
          if (last_q) rdata1_d = mem_dout;
          else        rdata0_d = mem_dout;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign mem_we   = (state_q == ACCESS) && we_q;
  assign m0_ack   = (state_q == ACK) && !last_q;
  assign m1_ack   = (state_q == ACK) &&  last_q;
  assign busy     = (state_q != IDLE);
  assign gnt_id   = last_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small behavioural memory (combinational read, write on posedge).
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_we, busy, gnt_id;

  logic [31:0] mem [0:15];
  int          wr_edges = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .busy(busy), .gnt_id(gnt_id)
  );

  assign mem_dout = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[3:0]] <= mem_din;
      wr_edges = wr_edges + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] data);
    if (id) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = data;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = data;
    end
  endtask

  // Single uncontended transaction: ack expected on the 2nd edge after the request.
  task automatic xfer(input bit id, input bit we, input logic [31:0] addr,
                      input logic [31:0] data, input string tag);
    int cyc = 0;
    bit seen = 0;
    int w0 = wr_edges;
    drive(id, 1'b1, we, addr, data);
    while (!seen && cyc < 6) begin
      tick();
      cyc++;
      if (id ? m1_ack : m0_ack) seen = 1;
    end
    check_eq({tag, " latency"}, cyc, 2);
    check_eq({tag, " other_ack"}, {31'd0, id ? m0_ack : m1_ack}, 0);
    check_eq({tag, " gnt_id"}, {31'd0, gnt_id}, {31'd0, id});
    drive(id, 1'b0, we, addr, data);
    tick();
    check_eq({tag, " busy_after"}, {31'd0, busy}, 0);
    check_eq({tag, " wr_edges"}, wr_edges - w0, we ? 1 : 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " busy"},     {31'd0, busy},   0);
    check_eq({tag, " mem_we"},   {31'd0, mem_we}, 0);
    check_eq({tag, " acks"},     {30'd0, m1_ack, m0_ack}, 0);
    check_eq({tag, " mem_addr"}, mem_addr, 32'h0);
    check_eq({tag, " mem_din"},  mem_din,  32'h0);
    check_eq({tag, " m0_rdata"}, m0_rdata, 32'h0);
    check_eq({tag, " m1_rdata"}, m1_rdata, 32'h0);
    check_eq({tag, " gnt_id"},   {31'd0, gnt_id}, 1);
  endtask

  initial begin
    int a0, a1, nack, w0;
    bit seq [4];
    bit gid [4];

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 32'h0, 32'h0);
    #12;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic write then readback from m0
    xfer(0, 1, 32'h0, 32'hAAAA_AAAA, "m0_wr0");
    check_eq("mem0_after_wr", mem[0], 32'hAAAA_AAAA);
    xfer(0, 0, 32'h0, 32'h0, "m0_rd0");
    check_eq("m0_rdata_rd0", m0_rdata, 32'hAAAA_AAAA);

    // Simultaneous writes right after reset: m0 wins first contention
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    check_eq("rst2 gnt_id", {31'd0, gnt_id}, 1);
    tick();
    drive(0, 1, 1, 32'h1, 32'hFFFF_ABC0);
    drive(1, 1, 1, 32'h2, 32'hFFFF_FFFF);
    a0 = -1; a1 = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (m0_ack && m1_ack) check_eq("both_ack", 1, 0);
      if (m0_ack) begin a0 = c; m0_req = 1'b0; end
      if (m1_ack) begin a1 = c; m1_req = 1'b0; end
    end
    check_eq("contend m0 ack cyc", a0, 2);
    check_eq("contend m1 ack cyc", a1, 5);
    check_eq("mem1", mem[1], 32'hFFFF_ABC0);
    check_eq("mem2", mem[2], 32'hFFFF_FFFF);
    xfer(0, 0, 32'h1, 32'h0, "m0_rd1");
    check_eq("m0_rdata_rd1", m0_rdata, 32'hFFFF_ABC0);
    xfer(1, 0, 32'h2, 32'h0, "m1_rd2");
    check_eq("m1_rdata_rd2", m1_rdata, 32'hFFFF_FFFF);

    // Continuous reads from both for 12 cycles
    drive(0, 1, 0, 32'h1, 32'h0);
    drive(1, 1, 0, 32'h2, 32'h0);
    nack = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (m0_ack && m1_ack) check_eq("rr both_ack", 1, 0);
      if ((m0_ack || m1_ack) && nack < 4) begin
        seq[nack] = m1_ack;
        gid[nack] = gnt_id;
        nack++;
      end
    end
    drive(0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 32'h0, 32'h0);
    tick();
    check_eq("rr ack count", nack, 4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rr seq%0d", k), {31'd0, seq[k]}, k % 2);
      check_eq($sformatf("rr gnt%0d", k), {31'd0, gid[k]}, k % 2);
    end
    check_eq("rr m0_rdata", m0_rdata, 32'hFFFF_ABC0);
    check_eq("rr m1_rdata", m1_rdata, 32'hFFFF_FFFF);

    // Per-requester rdata isolation; writes leave rdata alone
    xfer(0, 1, 32'h4, 32'h1234_5678, "m0_wr4");
    xfer(0, 0, 32'h4, 32'h0, "m0_rd4");
    check_eq("m0_rdata_rd4", m0_rdata, 32'h1234_5678);
    xfer(1, 1, 32'h3, 32'h0000_FFFF, "m1_wr3");
    check_eq("m1_rdata_after_wr", m1_rdata, 32'hFFFF_FFFF);
    xfer(1, 0, 32'h3, 32'h0, "m1_rd3");
    check_eq("m1_rdata_rd3", m1_rdata, 32'h0000_FFFF);
    check_eq("m0_rdata_kept", m0_rdata, 32'h1234_5678);

    // Reset during ACCESS of an m1 write: no write, no ack
    w0 = wr_edges;
    drive(1, 1, 1, 32'h2, 32'h5555_5555);
    tick();
    check_eq("rstmid mem_we_before", {31'd0, mem_we}, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rstmid");
    #2 rst = 1'b0;
    drive(1, 0, 0, 32'h0, 32'h0);
    nack = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (m0_ack || m1_ack) nack++;
    end
    check_eq("rstmid no_ack", nack, 0);
    check_eq("rstmid no_write", wr_edges - w0, 0);
    check_eq("rstmid mem2", mem[2], 32'hFFFF_FFFF);

    // m0 drops req during ACCESS: write still commits and ack pulses once
    w0 = wr_edges;
    drive(0, 1, 1, 32'h0, 32'hAAAA_0000);
    tick();
    check_eq("drop in_access", {31'd0, busy}, 1);
    m0_req = 1'b0;
    nack = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (m0_ack) nack++;
      if (m1_ack) check_eq("drop m1_ack", 1, 0);
    end
    check_eq("drop ack once", nack, 1);
    check_eq("drop busy", {31'd0, busy}, 0);
    check_eq("drop wr_edges", wr_edges - w0, 1);
    check_eq("drop mem0", mem[0], 32'hAAAA_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, width of every address port.
REQ-002 Parameter DATA_W, 32, width of every data port.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 m0_req, m1_req  input  1 each  access request from requester 0 (CPU) / 1 (DMA).
REQ-006 m0_we, m1_we  input  1 each  1 = write, 0 = read.
REQ-007 m0_addr, m1_addr  input  ADDR_W each  byte address passed unchanged to memory.
REQ-008 m0_wdata, m1_wdata  input  DATA_W each  write data.
REQ-009 m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
REQ-010 m0_rdata, m1_rdata  output  DATA_W each  registered read data per requester.
REQ-011 mem_addr  output  ADDR_W  drives dm_4k addr.
REQ-012 mem_din  output  DATA_W  drives dm_4k din.
REQ-013 mem_we  output  1  drives dm_4k DMWr.
REQ-014 mem_dout  input  DATA_W  from dm_4k dout (combinational read).
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 gnt_id  output  1  index of requester owning the current or last transaction.

Function
REQ-017 FSM states IDLE, ACCESS, ACK; transitions IDLE->ACCESS when any req=1 at a rising edge, ACCESS->ACK unconditionally, ACK->IDLE unconditionally.
REQ-018 In IDLE with one req high, that requester is granted; with both high, grant goes to the requester not equal to last_gnt (round-robin).
REQ-019 last_gnt updates to the granted index on the IDLE->ACCESS edge; gnt_id equals last_gnt.
REQ-020 On the IDLE->ACCESS edge, mem_addr and mem_din load the granted requester's addr/wdata, and a we register loads its we bit; mem_addr/mem_din hold until the next grant.
REQ-021 mem_we = 1 only in ACCESS with the registered we bit = 1, so exactly one memory write edge occurs per write transaction (the edge leaving ACCESS).
REQ-022 On the ACCESS->ACK edge, for a read, mem_dout is captured into the granted requester's rdata register; the other requester's rdata and all rdata on writes are unchanged.
REQ-023 mX_ack = 1 only in ACK and only for the granted requester; latency from request sampled to ack high is 2 cycles; throughput one transaction per 3 cycles.
REQ-024 Requester holds req, we, addr, wdata stable until it sees ack, and drops req (or presents a new request) after the ack edge; req is not sampled in ACCESS or ACK.
REQ-025 A req deasserted during ACCESS does not abort: the write commits, the read captures, the ack still pulses.
REQ-026 Addresses are not decoded or bounded; range and alignment are the memory's concern.
REQ-027 Starvation-free: under continuous requests from both, grants alternate 0,1,0,1...

Reset
REQ-028 rst = 1 forces immediately, independent of clk: state IDLE, mem_we 0, m0_ack/m1_ack 0, busy 0, mem_addr 0, mem_din 0, m0_rdata/m1_rdata 0, last_gnt 1 (requester 0 wins the first contention), gnt_id 1.
REQ-029 Reset asserted during ACCESS drops mem_we asynchronously; the transaction is lost, no ack is issued, and no write occurs unless the clk edge precedes rst.
REQ-030 First grant possible at the first rising edge after rst deasserts.

Verification
REQ-031 m0 write addr 0x0, data 0xAAAA_AAAA; then m0 read addr 0x0 -> mem_we high exactly one cycle, m0_ack 2 cycles after each request, m0_rdata = 0xAAAA_AAAA.
REQ-032 m0 and m1 request together after reset (m0 write 0x1/0xFFFF_ABC0, m1 write 0x2/0xFFFF_FFFF) -> m0 served first, m1 ack 3 cycles after m0 ack; readback of 0x1 and 0x2 returns the respective data.
REQ-033 Both requesters continuously requesting reads for 12 cycles -> 4 acks alternating 0,1,0,1; gnt_id toggles per grant.
REQ-034 m1 read addr 0x3 holding 0x0000_FFFF while m0_rdata = 0x1234_5678 -> m1_rdata = 0x0000_FFFF, m0_rdata unchanged.
REQ-035 m1 write to 0x2, rst pulsed mid-ACCESS before the clk edge -> mem_we falls immediately, no ack, all outputs at reset values, location 0x2 unchanged.
REQ-036 m0 drops req during ACCESS of a write to 0x0 with 0xAAAA_0000 -> write still commits, m0_ack pulses once, FSM returns to IDLE with busy 0.
